block_ram_dp: RTL and testbench

Parametrised dual-port successor to the single-port scratch RAM. Port A is byte-addressed read/write with sub-word shifting and per-byte write masks. Port B is read-only. The block adds a post-reset clear sequencer, an optional output register stage, and write-first collision forwarding. It serves as the instruction/data store for the core and a debug or DMA read path.

---
 rtl/block_ram_pkg.sv | 31 +++
 rtl/block_ram_merge.sv | 37 +++
 rtl/block_ram_dp.sv | 145 ++++++++++++++
 tb/tb_block_ram_dp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_ram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
//   state_e    : clear sequencer states (CLEAR while zeroing, READY afterwards)
//   lane_shift : moves a byte-0-justified data word up by a byte offset
//   mask_shift : moves a byte-0-justified lane mask up by a byte offset
// The helpers work on a fixed maximum width; callers truncate the result to
// their own word width, which is what drops bytes shifted past the word end.
package block_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int MAX_WIDTH = 1024;
  localparam int MAX_LANES = MAX_WIDTH / 8;

  function automatic logic [MAX_WIDTH-1:0] lane_shift(
    input logic [MAX_WIDTH-1:0] data,
    input int unsigned          offset
  );
    return data << (8 * offset);
  endfunction

  function automatic logic [MAX_LANES-1:0] mask_shift(
    input logic [MAX_LANES-1:0] mask,
    input int unsigned          offset
  );
    return mask << offset;
  endfunction

endpackage

// File: rtl/block_ram_merge.sv
// Combinational shift-and-merge for sub-word writes.
//   old_word : current contents of the addressed word
//   wdata    : write data, justified to byte 0
//   wmask    : per-byte write mask, justified to byte 0
//   offset   : byte offset inside the word
//   merged   : old_word with the shifted, masked bytes replaced
// Bytes pushed past the top of the word are discarded, never wrapped.
module block_ram_merge
  import block_ram_pkg::*;
#(
  parameter  int WIDTH     = 32,
  localparam int LANES     = WIDTH / 8,
  localparam int LANE_BITS = $clog2(LANES)
) (
  input  logic [WIDTH-1:0]     old_word,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [LANES-1:0]     wmask,
  input  logic [LANE_BITS-1:0] offset,
  output logic [WIDTH-1:0]     merged
);

  if (WIDTH % 8 != 0 || WIDTH < 16 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("block_ram_merge: WIDTH must be a multiple of 8 in [16, MAX_WIDTH]");
  end

  logic [WIDTH-1:0] data_sh;
  logic [LANES-1:0] mask_sh;

  // Truncating casts drop whatever was shifted beyond the word.
  assign data_sh = WIDTH'(lane_shift(MAX_WIDTH'(wdata), 32'(offset)));
  assign mask_sh = LANES'(mask_shift(MAX_LANES'(wmask), 32'(offset)));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = mask_sh[i] ? data_sh[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/block_ram_dp.sv
// Dual-port block RAM with post-reset clear and write-first forwarding.
//   clock, reset        : single clock, asynchronous active-high reset
//   busy                : high while the clear sequencer zeroes the array;
//                         every access is ignored while high
//   a_addr/a_cs/a_wren  : port A byte address, select, write enable
//   a_wdata/a_wmask     : port A write data and byte mask, byte-0 justified
//   a_rdata/a_rvalid    : port A result (merged word on writes)
//   b_addr/b_cs         : port B word read (low lane bits of b_addr ignored)
//   b_rdata/b_rvalid    : port B result; sees a same-cycle port A write
// Results appear 1 + OUT_REG cycles after the accepting edge; rdata is zero
// whenever rvalid is low.
module block_ram_dp
  import block_ram_pkg::*;
#(
  parameter  int    WIDTH          = 32,
  parameter  int    DEPTH          = 16384,
  parameter  string FILENAME       = "",
  parameter  int    CLEAR_ON_RESET = 1,
  parameter  int    OUT_REG        = 0,
  localparam int    LANES          = WIDTH / 8,
  localparam int    LANE_BITS      = $clog2(LANES),
  localparam int    ADDR_BITS      = $clog2(DEPTH) + LANE_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 busy,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic                 a_cs,
  input  logic                 a_wren,
  input  logic [WIDTH-1:0]     a_wdata,
  input  logic [LANES-1:0]     a_wmask,
  output logic [WIDTH-1:0]     a_rdata,
  output logic                 a_rvalid,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic                 b_cs,
  output logic [WIDTH-1:0]     b_rdata,
  output logic                 b_rvalid
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int STAGES   = 1 + ((OUT_REG != 0) ? 1 : 0);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("block_ram_dp: DEPTH must be a power of two, at least 2");
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // Clear sequencer: one word per cycle from 0 up to DEPTH-1
  // ---------------------------------------------------------------------
  state_e              state;
  logic [IDX_BITS-1:0] clr_cnt;

  assign busy = (state == CLEAR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_BITS'(DEPTH - 1)) state <= READY;
    end
  end

  // ---------------------------------------------------------------------
  // Address decode and access qualification
  // ---------------------------------------------------------------------
  logic [IDX_BITS-1:0]  a_word, b_word;
  logic [LANE_BITS-1:0] a_off;
  logic                 unused_b_lane;
  logic                 a_acc, a_we, b_acc;

  assign a_word        = a_addr[ADDR_BITS-1:LANE_BITS];
  assign a_off         = a_addr[LANE_BITS-1:0];
  assign b_word        = b_addr[ADDR_BITS-1:LANE_BITS];
  assign unused_b_lane = ^b_addr[LANE_BITS-1:0];

  assign a_acc = a_cs & ~busy;
  assign a_we  = a_acc & a_wren;
  assign b_acc = b_cs & ~busy;

  // ---------------------------------------------------------------------
  // Merge: one instance feeds the array write, port A's write-first result
  // and port B's collision forward, so all three always agree.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] a_old, a_merged, a_res, b_res;

  assign a_old = mem[a_word];

  block_ram_merge #(.WIDTH(WIDTH)) u_merge (
    .old_word (a_old),
    .wdata    (a_wdata),
    .wmask    (a_wmask),
    .offset   (a_off),
    .merged   (a_merged)
  );

  assign a_res = !a_acc ? '0 : (a_wren ? a_merged : a_old);
  assign b_res = !b_acc ? '0 :
                 (a_we && (a_word == b_word)) ? a_merged : mem[b_word];

  // Clear writes win over port A; port A is blocked while busy anyway.
  always_ff @(posedge clock) begin
    if (busy)      mem[clr_cnt] <= '0;
    else if (a_we) mem[a_word]  <= a_merged;
  end

  // ---------------------------------------------------------------------
  // Output pipelines: valid and data shift together, stage 1 is the
  // mandatory read register, stage 2 exists only with OUT_REG.
  // ---------------------------------------------------------------------
  logic [STAGES:1]            a_vld_pipe, b_vld_pipe;
  logic [STAGES:1][WIDTH-1:0] a_dat_pipe, b_dat_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_vld_pipe <= '0;
      b_vld_pipe <= '0;
      a_dat_pipe <= '0;
      b_dat_pipe <= '0;
    end else begin
      a_vld_pipe[1] <= a_acc;
      b_vld_pipe[1] <= b_acc;
      a_dat_pipe[1] <= a_res;
      b_dat_pipe[1] <= b_res;
      for (int s = 2; s <= STAGES; s++) begin
        a_vld_pipe[s] <= a_vld_pipe[s-1];
        b_vld_pipe[s] <= b_vld_pipe[s-1];
        a_dat_pipe[s] <= a_dat_pipe[s-1];
        b_dat_pipe[s] <= b_dat_pipe[s-1];
      end
    end
  end

  assign a_rdata  = a_dat_pipe[STAGES];
  assign a_rvalid = a_vld_pipe[STAGES];
  assign b_rdata  = b_dat_pipe[STAGES];
  assign b_rvalid = b_vld_pipe[STAGES];

endmodule

// File: tb/tb_block_ram_dp.sv
// Bench for block_ram_dp (WIDTH=32, DEPTH=16). Reference model is a plain
// word array updated byte by byte from the write rules.
module tb_block_ram_dp;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int OUT_REG = 0;
  localparam int LAT     = 1 + OUT_REG;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [5:0]  a_addr = '0;
  logic        a_cs = 1'b0, a_wren = 1'b0;
  logic [31:0] a_wdata = '0;
  logic [3:0]  a_wmask = '0;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic [5:0]  b_addr = '0;
  logic        b_cs = 1'b0;
  logic [31:0] b_rdata;
  logic        b_rvalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [DEPTH];

  block_ram_dp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FILENAME(""),
    .CLEAR_ON_RESET(1), .OUT_REG(OUT_REG)
  ) dut (
    .clock(clock), .reset(reset), .busy(busy),
    .a_addr(a_addr), .a_cs(a_cs), .a_wren(a_wren), .a_wdata(a_wdata),
    .a_wmask(a_wmask), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_addr(b_addr), .b_cs(b_cs), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-level write rule: byte b of the word takes wdata byte (b-off) when
  // that source byte exists and its mask bit is set.
  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] wm, input int off);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      int src;
      src = b - off;
      if (src >= 0 && wm[src]) r[8*b +: 8] = wd[8*src +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_cs = 1'b0; a_wren = 1'b0; b_cs = 1'b0;
  endtask

  // One access cycle; returns when its result is visible on the outputs.
  task automatic access(input logic acs, input logic awr, input logic [5:0] aad,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input logic bcs, input logic [5:0] bad);
    a_cs = acs; a_wren = awr; a_addr = aad; a_wdata = wd; a_wmask = wm;
    b_cs = bcs; b_addr = bad;
    tick();
    idle();
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    int n;
    idle();
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_a_rdata: got %h want 0", a_rdata); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_a_rvalid: got %b want 0", a_rvalid); end
    n_checks++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_b_rdata: got %h want 0", b_rdata); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_b_rvalid: got %b want 0", b_rvalid); end
    tick();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); end
    for (int w = 0; w < DEPTH; w++) model[w] = 32'h0;
    for (int w = 0; w < DEPTH; w++) begin
      access(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, {w[3:0], 2'($urandom_range(0, 3))});
      n_checks++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL clear_word%0d: got %h want 0", w, b_rdata); end
      n_checks++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL clear_rvalid%0d: got %b want 1", w, b_rvalid); end
    end
  endtask

  task automatic test_subword();
    access(1'b1, 1'b1, 6'd6, 32'h000000AB, 4'b0001, 1'b0, 6'd0);
    model[1] = merge_ref(model[1], 32'h000000AB, 4'b0001, 2);
    n_checks++; if (a_rdata !== 32'h00AB0000) begin n_fail++; $display("FAIL subword_wr_rdata: got %h want 00ab0000", a_rdata); end
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL subword_wr_rvalid: got %b want 1", a_rvalid); end
    access(1'b1, 1'b0, {4'd1, 2'($urandom_range(0, 3))}, $urandom, 4'hF, 1'b0, 6'd0);
    n_checks++; if (a_rdata !== 32'h00AB0000) begin n_fail++; $display("FAIL subword_rd: got %h want 00ab0000", a_rdata); end
    n_checks++; if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL subword_rd_rvalid: got %b want 1", a_rvalid); end
    tick();
    n_checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_after_read: got %b/%h want 0/0", a_rvalid, a_rdata); end
  endtask

  task automatic test_nowrap();
    access(1'b1, 1'b1, 6'd12, 32'h11223344, 4'hF, 1'b0, 6'd0);
    model[3] = 32'h11223344;
    access(1'b1, 1'b1, 6'd15, 32'h0000FFFF, 4'b0011, 1'b0, 6'd0);
    model[3] = merge_ref(model[3], 32'h0000FFFF, 4'b0011, 3);
    n_checks++; if (a_rdata !== 32'hFF223344) begin n_fail++; $display("FAIL nowrap_wr: got %h want ff223344", a_rdata); end
    access(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd13);
    n_checks++; if (b_rdata !== 32'hFF223344) begin n_fail++; $display("FAIL nowrap_word3: got %h want ff223344", b_rdata); end
    access(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd16);
    n_checks++; if (b_rdata !== model[4]) begin n_fail++; $display("FAIL nowrap_word4: got %h want %h", b_rdata, model[4]); end
  endtask

  task automatic test_collision();
    logic [31:0] wd, exp;
    logic [3:0]  wm;
    logic [1:0]  off;
    access(1'b1, 1'b1, 6'd20, 32'hDEADBEEF, 4'hF, 1'b1, {4'd5, 2'($urandom_range(0, 3))});
    model[5] = 32'hDEADBEEF;
    n_checks++; if (b_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL collide_b: got %h want deadbeef", b_rdata); end
    n_checks++; if (b_rvalid !== 1'b1) begin n_fail++; $display("FAIL collide_b_rvalid: got %b want 1", b_rvalid); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL collide_a: got %h want deadbeef", a_rdata); end
    wd = $urandom; wm = 4'($urandom_range(1, 15)); off = 2'($urandom_range(0, 3));
    exp = merge_ref(model[5], wd, wm, off);
    access(1'b1, 1'b1, {4'd5, off}, wd, wm, 1'b1, 6'd20);
    model[5] = exp;
    n_checks++; if (b_rdata !== exp) begin n_fail++; $display("FAIL collide_partial: got %h want %h", b_rdata, exp); end
  endtask

  task automatic test_cs_low();
    access(1'b1, 1'b1, 6'd8, 32'hCAFEF00D, 4'hF, 1'b0, 6'd0);
    model[2] = 32'hCAFEF00D;
    access(1'b0, 1'b1, {4'd2, 2'($urandom_range(0, 3))}, 32'h12345678, 4'hF, 1'b0, 6'd0);
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL cslow_rdata: got %h want 0", a_rdata); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL cslow_rvalid: got %b want 0", a_rvalid); end
    access(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd9);
    n_checks++; if (b_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL cslow_mem: got %h want cafef00d", b_rdata); end
  endtask

  task automatic test_reset_mid();
    int n;
    access(1'b1, 1'b1, 6'd28, $urandom | 32'h1, 4'hF, 1'b0, 6'd0);
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    repeat (7) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclear_busy7: got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclear_busy_rst: got %b want 1", busy); end
    tick();
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 10) begin
        a_cs = 1'b1; a_wren = 1'b1; a_addr = 6'd0; a_wdata = 32'hA5A5A5A5; a_wmask = 4'hF;
        b_cs = 1'b1; b_addr = 6'd0;
      end else idle();
      tick();
      n++;
      n_checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_fail++; $display("FAIL busy_rvalid: got %b/%b want 0/0", a_rvalid, b_rvalid); end
    end
    idle();
    repeat (LAT) tick();
    n_checks++; if (n != DEPTH) begin n_fail++; $display("FAIL restart_cycles: got %0d want %0d", n, DEPTH); end
    for (int w = 0; w < DEPTH; w++) model[w] = 32'h0;
    for (int w = 0; w < DEPTH; w++) begin
      access(1'b0, 1'b0, 6'd0, 32'h0, 4'h0, 1'b1, {w[3:0], 2'b00});
      n_checks++; if (b_rdata !== 32'h0) begin n_fail++; $display("FAIL restart_word%0d: got %h want 0", w, b_rdata); end
    end
  endtask

  task automatic test_random();
    logic [31:0] qa_d[$], qb_d[$];
    logic        qa_v[$], qb_v[$];
    logic [31:0] merged, ea, eb, da, db;
    logic        va, vb;
    logic [3:0]  aw, bw;
    for (int i = 0; i < 400 + LAT; i++) begin
      if (i < 400) begin
        a_cs    = ($urandom_range(0, 3) != 0);
        a_wren  = 1'($urandom_range(0, 1));
        a_addr  = 6'($urandom_range(0, 63));
        a_wdata = $urandom;
        a_wmask = 4'($urandom_range(0, 15));
        b_cs    = ($urandom_range(0, 3) != 0);
        b_addr  = ($urandom_range(0, 1) != 0) ? {a_addr[5:2], 2'($urandom_range(0, 3))}
                                               : 6'($urandom_range(0, 63));
      end else idle();
      aw = a_addr[5:2];
      bw = b_addr[5:2];
      merged = merge_ref(model[aw], a_wdata, a_wmask, a_addr[1:0]);
      ea = a_cs ? (a_wren ? merged : model[aw]) : 32'h0;
      eb = b_cs ? ((a_cs && a_wren && aw == bw) ? merged : model[bw]) : 32'h0;
      qa_d.push_back(ea); qa_v.push_back(a_cs);
      qb_d.push_back(eb); qb_v.push_back(b_cs);
      if (a_cs && a_wren) model[aw] = merged;
      tick();
      if (qa_d.size() == LAT) begin
        da = qa_d.pop_front(); va = qa_v.pop_front();
        db = qb_d.pop_front(); vb = qb_v.pop_front();
        n_checks++; if (a_rvalid !== va) begin n_fail++; $display("FAIL rand_a_rvalid@%0d: got %b want %b", i, a_rvalid, va); end
        n_checks++; if (a_rdata !== da) begin n_fail++; $display("FAIL rand_a_rdata@%0d: got %h want %h", i, a_rdata, da); end
        n_checks++; if (b_rvalid !== vb) begin n_fail++; $display("FAIL rand_b_rvalid@%0d: got %b want %b", i, b_rvalid, vb); end
        n_checks++; if (b_rdata !== db) begin n_fail++; $display("FAIL rand_b_rdata@%0d: got %h want %h", i, b_rdata, db); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_subword();
    test_nowrap();
    test_collision();
    test_cs_low();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
